// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath: LFSR polynomial, default seed,
// position-generator state encoding and a constant-friendly clog2.
package snake_pkg;

    localparam logic [15:0] LFSR_MASK = 16'hB400;  // x^16+x^14+x^13+x^11+1, Galois form
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CHECK = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result = result + 1;
        return result;
    endfunction

endpackage

// File: rtl/random_grid_position_if.sv
// Request / candidate-check / result signals of the food-position generator.
// The slave side is the generator, the master side is controller plus occupancy checker.
interface random_grid_position_if #(
    parameter int BIT = 10
);
    logic           entropy_in;
    logic           req;
    logic           busy;
    logic [BIT-1:0] cand_x;
    logic [BIT-1:0] cand_y;
    logic           cand_valid;
    logic           check_ack;
    logic           occupied;
    logic [BIT-1:0] x_out;
    logic [BIT-1:0] y_out;
    logic           pos_valid;
    logic           fallback;

    modport slave (
        input  entropy_in, req, check_ack, occupied,
        output busy, cand_x, cand_y, cand_valid, x_out, y_out, pos_valid, fallback
    );

    modport master (
        output entropy_in, req, check_ack, occupied,
        input  busy, cand_x, cand_y, cand_valid, x_out, y_out, pos_valid, fallback
    );
endinterface

// File: rtl/lfsr_galois.sv
// Free-running right-shift Galois LFSR with an entropy bit folded into the feedback.
// An all-zero next value is replaced by SEED so the register can never lock up.
module lfsr_galois
    import snake_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] MASK  = LFSR_MASK,
    parameter logic [WIDTH-1:0] SEED  = LFSR_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entropy_in,
    output logic [WIDTH-1:0] state
);

    logic             feedback;
    logic [WIDTH-1:0] state_next;

    always_comb begin
        feedback   = state[0] ^ entropy_in;
        state_next = (state >> 1) ^ (feedback ? MASK : '0);
        if (state_next == '0) state_next = SEED;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SEED;
        else       state <= state_next;
    end

endmodule

// File: rtl/random_grid_position.sv
// Grid-aligned random food position generator: rejection-samples LFSR bits onto the
// cell grid and redraws occupied cells up to MAX_RETRY times before giving up.
module random_grid_position
    import snake_pkg::*;
#(
    parameter int                BIT       = 10,
    parameter int                MIN_X     = 40,
    parameter int                MAX_X     = 600,
    parameter int                MIN_Y     = 40,
    parameter int                MAX_Y     = 440,
    parameter int                CELL_LOG2 = 3,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_SEED,
    parameter int                MAX_RETRY = 15,
    parameter int                START_X   = 200,
    parameter int                START_Y   = 240
) (
    input logic                   clk,
    input logic                   reset,
    random_grid_position_if.slave bus
);

    localparam int NX      = (MAX_X - MIN_X) >> CELL_LOG2;
    localparam int NY      = (MAX_Y - MIN_Y) >> CELL_LOG2;
    localparam int IX_W    = clog2(NX);
    localparam int IY_W    = clog2(NY);
    localparam int XL_W    = IX_W + 1;
    localparam int YL_W    = IY_W + 1;
    localparam int RETRY_W = clog2(MAX_RETRY + 1);
    localparam logic [XL_W-1:0]    NX_LIM    = XL_W'(NX);
    localparam logic [YL_W-1:0]    NY_LIM    = YL_W'(NY);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    if (IX_W + IY_W > LFSR_W) begin : g_lfsr_width_check
        $error("random_grid_position: LFSR_W too small for the grid index bits");
    end
    if (NX == 0 || NY == 0 || ((MAX_X - MIN_X) % (1 << CELL_LOG2)) != 0 ||
        ((MAX_Y - MIN_Y) % (1 << CELL_LOG2)) != 0) begin : g_bounds_check
        $error("random_grid_position: playfield span must be a nonzero multiple of the cell size");
    end

    logic [LFSR_W-1:0]  lfsr;
    logic               unused_lfsr_bits;
    logic [IX_W-1:0]    xi;
    logic [IY_W-1:0]    yi;
    logic               in_range;
    logic [BIT-1:0]     draw_x;
    logic [BIT-1:0]     draw_y;

    state_t             state;
    logic               req_q;
    logic               req_rise;
    logic [RETRY_W-1:0] retry;
    logic               busy;
    logic               cand_valid;
    logic               pos_valid;
    logic               fallback;
    logic [BIT-1:0]     cand_x;
    logic [BIT-1:0]     cand_y;
    logic [BIT-1:0]     x_out;
    logic [BIT-1:0]     y_out;

    lfsr_galois #(
        .WIDTH (LFSR_W),
        .MASK  (LFSR_W'(LFSR_MASK)),
        .SEED  (SEED)
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .entropy_in (bus.entropy_in),
        .state      (lfsr)
    );

    // Low LFSR bits index the grid; out-of-range indices are simply redrawn next cycle.
    assign xi               = lfsr[IX_W-1:0];
    assign yi               = lfsr[IX_W+IY_W-1:IX_W];
    assign in_range         = ({1'b0, xi} < NX_LIM) && ({1'b0, yi} < NY_LIM);
    assign draw_x           = BIT'(MIN_X) + (BIT'(xi) << CELL_LOG2);
    assign draw_y           = BIT'(MIN_Y) + (BIT'(yi) << CELL_LOG2);
    assign unused_lfsr_bits = ^lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            req_rise   <= 1'b0;
            retry      <= '0;
            busy       <= 1'b0;
            cand_valid <= 1'b0;
            pos_valid  <= 1'b0;
            fallback   <= 1'b0;
            cand_x     <= BIT'(MIN_X);
            cand_y     <= BIT'(MIN_Y);
            x_out      <= BIT'(START_X);
            y_out      <= BIT'(START_Y);
        end else begin
            req_q     <= bus.req;
            req_rise  <= bus.req & ~req_q;
            pos_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_rise) begin
                        retry    <= '0;
                        fallback <= 1'b0;
                        busy     <= 1'b1;
                        state    <= DRAW;
                    end
                end
                DRAW: begin
                    if (in_range) begin
                        cand_x     <= draw_x;
                        cand_y     <= draw_y;
                        cand_valid <= 1'b1;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (bus.check_ack) begin
                        cand_valid <= 1'b0;
                        if (!bus.occupied) begin
                            x_out     <= cand_x;
                            y_out     <= cand_y;
                            pos_valid <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else if (retry == RETRY_LIM) begin
                            // Out of retries: keep the previous position and flag it.
                            fallback  <= 1'b1;
                            pos_valid <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            retry <= retry + RETRY_W'(1);
                            state <= DRAW;
                        end
                    end
                end
                default: begin
                    busy       <= 1'b0;
                    cand_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.cand_x     = cand_x;
    assign bus.cand_y     = cand_y;
    assign bus.cand_valid = cand_valid;
    assign bus.x_out      = x_out;
    assign bus.y_out      = y_out;
    assign bus.pos_valid  = pos_valid;
    assign bus.fallback   = fallback;

endmodule

// File: tb/tb_random_grid_position.sv
// Scoreboard bench for random_grid_position: a reference LFSR predicts each candidate,
// the emulated checker pushes the expected outcome, pos_valid pops and compares.
`timescale 1ns/1ps
module tb_random_grid_position;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    random_grid_position_if #(.BIT(10)) bus();

    random_grid_position dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic        z_entropy;
    logic [15:0] z_state;

    lfsr_galois #(.WIDTH(16), .MASK(16'hB400), .SEED(16'hACE1)) z_lfsr (
        .clk        (clk),
        .reset      (reset),
        .entropy_in (z_entropy),
        .state      (z_state)
    );

    typedef struct { int x; int y; int fb; } exp_t;
    exp_t sbq[$];
    exp_t e;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ack_delay   = 0;
    int occ_n       = 0;
    int wait_n      = 0;
    int verdicts    = 0;
    int retry_m     = 0;
    int pv_count    = 0;
    int cand_count  = 0;
    int hs_at_pv    = 0;
    int last_x      = 200;
    int last_y      = 240;
    int exp_cx      = 40;
    int exp_cy      = 40;
    int req_cyc     = 0;
    int min_lat     = 1000000;
    int lat;
    bit cv_seen     = 1'b0;
    logic [15:0] m_cur, m_prev;

    task automatic check_val(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic ent);
        logic [15:0] n;
        n = (s >> 1) ^ ((s[0] ^ ent) ? 16'hB400 : 16'h0000);
        if (n == 16'h0000) n = 16'hACE1;
        return n;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cur  = 16'hACE1;
            m_prev = 16'hACE1;
        end else begin
            m_prev = m_cur;
            m_cur  = lfsr_step(m_cur, bus.entropy_in);
        end
    end

    // Checker emulation and scoreboard, all sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            bus.check_ack = 1'b0;
            bus.occupied  = 1'b0;
            cv_seen       = 1'b0;
            sbq.delete();
            last_x        = 200;
            last_y        = 240;
        end else begin
            if (bus.cand_valid && !cv_seen) begin
                cv_seen = 1'b1;
                wait_n  = 0;
                cand_count++;
                exp_cx = 40 + int'(m_prev[6:0]) * 8;
                exp_cy = 40 + int'(m_prev[12:7]) * 8;
                check_val("draw_in_range", int'(m_prev[6:0] < 7'd70 && m_prev[12:7] < 6'd50), 1);
                check_val("cand_x_grid", int'(bus.cand_x >= 10'd40 && bus.cand_x < 10'd600 &&
                                              bus.cand_x[2:0] == 3'd0), 1);
                check_val("cand_y_grid", int'(bus.cand_y >= 10'd40 && bus.cand_y < 10'd440 &&
                                              bus.cand_y[2:0] == 3'd0), 1);
            end
            if (bus.cand_valid) begin
                check_val("cand_x", int'(bus.cand_x), exp_cx);
                check_val("cand_y", int'(bus.cand_y), exp_cy);
                if (wait_n >= ack_delay) begin
                    bus.check_ack = 1'b1;
                    bus.occupied  = (verdicts < occ_n);
                    verdicts++;
                    if (!bus.occupied) begin
                        sbq.push_back('{exp_cx, exp_cy, 0});
                        last_x = exp_cx;
                        last_y = exp_cy;
                    end else if (retry_m == 15) begin
                        sbq.push_back('{last_x, last_y, 1});
                    end else begin
                        retry_m++;
                    end
                end else begin
                    bus.check_ack = 1'b0;
                    bus.occupied  = 1'($urandom_range(0, 1));
                end
                wait_n++;
            end else begin
                cv_seen       = 1'b0;
                bus.check_ack = 1'($urandom_range(0, 1));
                bus.occupied  = 1'($urandom_range(0, 1));
            end
            if (bus.pos_valid) begin
                pv_count++;
                hs_at_pv = verdicts;
                lat = cyc - req_cyc - 1;
                if (lat < min_lat) min_lat = lat;
                check_val("busy_with_pos_valid", int'(bus.busy), 0);
                if (sbq.size() == 0) begin
                    check_val("unexpected_pos_valid", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check_val("x_out", int'(bus.x_out), e.x);
                    check_val("y_out", int'(bus.y_out), e.y);
                    check_val("fallback", int'(bus.fallback), e.fb);
                end
            end
        end
    end

    task automatic do_req(input int hold);
        @(negedge clk);
        retry_m    = 0;
        verdicts   = 0;
        req_cyc    = cyc;
        bus.req    = 1'b1;
        repeat (hold) @(negedge clk);
        bus.req    = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (pv_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (pv_count < target) check_val(tag, pv_count, target);
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        while (!bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("busy_seen", int'(bus.busy), 1);
    endtask

    task automatic reset_mid_cycle();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("rst_x_out", int'(bus.x_out), 200);
        check_val("rst_y_out", int'(bus.y_out), 240);
        check_val("rst_busy", int'(bus.busy), 0);
        check_val("rst_pos_valid", int'(bus.pos_valid), 0);
        check_val("rst_fallback", int'(bus.fallback), 0);
        check_val("rst_cand_valid", int'(bus.cand_valid), 0);
        check_val("rst_cand_x", int'(bus.cand_x), 40);
        check_val("rst_lfsr", int'(z_state), 16'hACE1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        logic [15:0] zm;
        reset          = 1'b0;
        bus.req        = 1'b0;
        bus.entropy_in = 1'b0;
        z_entropy      = 1'b1;

        reset_mid_cycle();
        #2 reset = 1'b0;

        // Steer the spare LFSR with entropy = lsb so it shifts down to zero.
        zm = 16'hACE1;
        for (int i = 0; i < 16; i++) begin
            z_entropy = zm[0];
            @(posedge clk);
            #1;
            zm = lfsr_step(zm, z_entropy);
            check_val("lfsr_step", int'(z_state), int'(zm));
        end
        check_val("lfsr_zero_recover", int'(z_state), 16'hACE1);
        z_entropy = 1'b0;

        ack_delay = 0;
        occ_n     = 0;
        base      = pv_count;
        for (int i = 0; i < 1000; i++) begin
            do_req(1);
            wait_done(base + i + 1, 200, "free_timeout");
        end
        check_val("free_count", pv_count, base + 1000);
        check_val("best_latency", min_lat, 3);

        occ_n = 1000;
        base  = pv_count;
        do_req(1);
        wait_done(base + 1, 400, "occ_timeout");
        check_val("occ_checks", hs_at_pv, 16);
        repeat (3) @(negedge clk);
        check_val("fallback_held", int'(bus.fallback), 1);

        occ_n = 3;
        base  = pv_count;
        n     = cand_count;
        do_req(1);
        wait_busy(10);
        check_val("fallback_cleared", int'(bus.fallback), 0);
        wait_done(base + 1, 200, "occ3_timeout");
        check_val("occ3_handshakes", hs_at_pv, 4);
        check_val("occ3_candidates", cand_count - n, 4);

        ack_delay = 5;
        occ_n     = 0;
        base      = pv_count;
        do_req(1);
        wait_busy(10);
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        wait_done(base + 1, 200, "busy_req_timeout");
        repeat (20) @(negedge clk);
        check_val("req_while_busy_ignored", pv_count, base + 1);

        ack_delay = 0;
        base      = pv_count;
        do_req(40);
        repeat (20) @(negedge clk);
        check_val("held_req_single", pv_count, base + 1);

        ack_delay = 100000;
        base      = pv_count;
        do_req(1);
        n = 0;
        while (!bus.cand_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("abort_cand_valid", int'(bus.cand_valid), 1);
        reset_mid_cycle();
        #2 reset = 1'b0;
        ack_delay = 0;
        repeat (10) @(negedge clk);
        check_val("abort_no_pos_valid", pv_count, base);
        check_val("abort_idle", int'(bus.busy), 0);

        base = pv_count;
        do_req(1);
        wait_done(base + 1, 200, "post_abort_timeout");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/random_grid_position.md
# random_grid_position

Grid-aligned pseudo-random position generator for the snake game. It draws food-spawn coordinates from a free-running LFSR, maps them onto a cell grid inside the playfield, and asks an external occupancy checker (the snake-body logic) whether each candidate is free. Occupied candidates are redrawn, up to a bounded retry count. It sits between the game controller, which requests a new position, and the food register or renderer, which consumes `x_out`/`y_out`.

## Interface
Parameters:
- `BIT`, 10: coordinate width.
- `MIN_X`, 40 / `MAX_X`, 600: playfield x bounds in pixels; `MAX_X-MIN_X` must be a nonzero multiple of the cell size.
- `MIN_Y`, 40 / `MAX_Y`, 440: playfield y bounds, with the same rule.
- `CELL_LOG2`, 3: cell size is `2**CELL_LOG2` px.
- `LFSR_W`, 16: LFSR width.
- `SEED`, 16'hACE1: LFSR reset and recovery value; must be nonzero.
- `MAX_RETRY`, 15: maximum number of occupied redraws.
- `START_X`, 200 / `START_Y`, 240: position outputs after reset.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `entropy_in` in 1: any async-safe, already-synchronised bit (e.g. a button), mixed into the LFSR.
- `req` in 1: new-position request; acts on its rising edge.
- `busy` out 1: high whenever the state is not IDLE.
- `cand_x`, `cand_y` out BIT: candidate coordinates; stable while `cand_valid` is high.
- `cand_valid` out 1: candidate presented to the checker.
- `check_ack` in 1: checker verdict is valid this cycle.
- `occupied` in 1: verdict, sampled only when `cand_valid & check_ack`.
- `x_out`, `y_out` out BIT: last accepted position.
- `pos_valid` out 1: one-cycle pulse when a request completes.
- `fallback` out 1: set on completion by retry exhaustion; cleared when the next request is accepted.

## Operation
- Derived constants: `NX=(MAX_X-MIN_X)>>CELL_LOG2` (70), `NY=(MAX_Y-MIN_Y)>>CELL_LOG2` (50). `IX_W=clog2(NX)`, `IY_W=clog2(NY)`. Requires `IX_W+IY_W<=LFSR_W`; violation is an elaboration error.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). It advances every cycle in every state. `entropy_in` is XORed into the bit-0 feedback. If the next value would be all-zero, `SEED` is loaded instead.
- Edge detect: a registered copy of `req`; `req & ~req_q` is a rising edge. A rising edge while `busy=1` is dropped, with no queuing.
- States:
  - IDLE: on a rising edge, clear `retry` and `fallback`, then go to DRAW.
  - DRAW: `xi=lfsr[IX_W-1:0]`, `yi=lfsr[IX_W+IY_W-1:IX_W]`. If `xi<NX` and `yi<NY`, register `cand_x=MIN_X+(xi<<CELL_LOG2)` and `cand_y=MIN_Y+(yi<<CELL_LOG2)`, then go to CHECK. Otherwise stay in DRAW. Rejection sampling does not count as a retry.
  - CHECK: `cand_valid=1`; wait for `check_ack`, with no timeout.
    - `!occupied`: load `x_out`/`y_out` from the candidate, pulse `pos_valid`, go to IDLE.
    - `occupied` and `retry<MAX_RETRY`: `retry++`, go to DRAW.
    - `occupied` and `retry==MAX_RETRY`: `x_out`/`y_out` unchanged, set `fallback`, pulse `pos_valid`, go to IDLE.
- `retry` counter width is `clog2(MAX_RETRY+1)`.
- Arithmetic is unsigned at BIT width. Every candidate satisfies `MIN<=cand<MAX` and is cell-aligned relative to MIN.

## Timing
- Reset values: state IDLE; `lfsr=SEED`; `x_out=START_X`; `y_out=START_Y`; `cand_x=MIN_X`; `cand_y=MIN_Y`; `busy`, `cand_valid`, `pos_valid`, `fallback`, `req_q` all 0.
- Reset asserted in any state aborts the request immediately. No `pos_valid` is produced for the aborted request.
- `req` rising at edge n (seen by `req_q` logic) means `busy=1` after edge n+1.
- Best case: the first draw is in range, so `cand_valid=1` after edge n+2. `check_ack` in the same cycle gives `pos_valid=1` after edge n+3, and `busy=0` in that same cycle.
- `check_ack` may be combinational from `cand_*`. When `cand_valid=0`, `check_ack` is ignored.
- `cand_*` change only on the DRAW→CHECK transition.
- `pos_valid` and `busy` are never high in the same cycle.
- A `req` still held high after completion does not retrigger; a new rising edge is required.

## Structure
- Shared package `snake_pkg`: LFSR polynomial mask, default seed, state encoding (IDLE/DRAW/CHECK) and the clog2 function.
- One sub-module, `lfsr_galois`, with parameters width, mask and seed. Its ports are `clk`, `reset`, `entropy_in`, `state`, and it includes the zero-lock recovery.
- The FSM, edge detect, range mapping and retry counter live in the top module.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle. Outputs 200/240 immediately; `busy=0`, `pos_valid=0`, `fallback=0`.
- Free checker: tie `check_ack=1`, `occupied=0`; pulse `req` 1000 times. Every `pos_valid` has `40<=x_out<600`, `40<=y_out<440`, and both `(x-40)%8==0` and `(y-40)%8==0`. Best case latency is 3 cycles.
- Always occupied: after exactly 16 checks, `pos_valid` pulses with `fallback=1` and `x_out`/`y_out` still at their previous values. The next `req` clears `fallback`.
- Occupied on the first 3 verdicts, then free: exactly 4 `cand_valid` handshakes, `fallback=0`, and the accepted position equals the 4th candidate.
- Protocol: a `req` edge while busy is ignored (one `pos_valid` only). Holding `req` high produces a single completion. Delaying `check_ack` by 5 cycles keeps `cand_*` stable throughout.
- Reset during CHECK, with `cand_valid=1`: returns to IDLE with no `pos_valid`. Also force the LFSR to zero and confirm the next value is `SEED` (16'hACE1).
